// File: rtl/waveform_buffer.sv
// waveform_buffer: decimating circular sample store for the waveform display.
// Kept samples go into a DEPTH-entry ring; scan-out reads one sample per
// column, anchored to a base pointer snapshotted once per frame at
// (vcount==V_LATCH, hcount==0).
// Optional feature macro: WAVEBUF_FREEZE_EN adds a `freeze` input that
// suspends writes and snapshot updates so the display holds still.
module waveform_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int DECIM      = 4,
  parameter int V_LATCH    = 768
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
`ifdef WAVEBUF_FREEZE_EN
  input  logic                  freeze,
`endif
  output logic [DATA_WIDTH-1:0] signal_out,
  output logic                  frame_ready,
  output logic [DEPTH_LOG2:0]   fill_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  // Compare width wide enough for both hcount (11 bits) and fill values.
  localparam int CW    = (DEPTH_LOG2 + 1 > 11) ? DEPTH_LOG2 + 2 : 12;
  localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DCW-1:0]      DCNT_TOP = DCW'(DECIM - 1);

  logic                  live;
  logic [DCW-1:0]        dcnt;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] base;
  logic [DEPTH_LOG2:0]   fill_lat;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  strobe;
  logic                  wr_en;
  logic                  snap;
  logic                  rd_ok;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic [DATA_WIDTH-1:0] ram [DEPTH];

  // Entry count saturates once the ring has been filled completely.
  function automatic logic [DEPTH_LOG2:0] sat_inc(input logic [DEPTH_LOG2:0] v);
    return (v == FULL) ? v : v + 1'b1;
  endfunction

  // Decimation phase counter wraps after DECIM valid strobes.
  function automatic logic [DCW-1:0] dcnt_next(input logic [DCW-1:0] v);
    return (v == DCNT_TOP) ? '0 : v + 1'b1;
  endfunction

`ifdef WAVEBUF_FREEZE_EN
  assign live = ~freeze;
`else
  assign live = 1'b1;
`endif

  assign strobe  = live & sample_valid;
  assign wr_en   = strobe & (dcnt == '0);
  assign snap    = (vcount == 10'(V_LATCH)) && (hcount == 11'd0);
  assign rd_addr = base + hcount[DEPTH_LOG2-1:0];
  assign rd_ok   = (CW'(hcount) < CW'(fill_lat)) && (CW'(hcount) < CW'(DEPTH));

  // Write side: decimator phase, write pointer and saturating fill count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dcnt       <= '0;
      wr_ptr     <= '0;
      fill_count <= '0;
    end else begin
      if (strobe) dcnt <= dcnt_next(dcnt);
      if (wr_en) begin
        wr_ptr     <= wr_ptr + 1'b1;
        fill_count <= sat_inc(fill_count);
      end
    end
  end

  // Frame snapshot: anchor base to the oldest entry once the ring is full.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base        <= '0;
      fill_lat    <= '0;
      frame_ready <= 1'b0;
    end else begin
      frame_ready <= snap;
      if (snap && live) begin
        base     <= (fill_count == FULL) ? wr_ptr : '0;
        fill_lat <= fill_count;
      end
    end
  end

  // ---- stage p0 -> p1: sample RAM, read-first on same-address collision ----
  always_ff @(posedge clock) begin
    if (wr_en) ram[wr_ptr] <= sample_in;
    rd_data_p1 <= ram[rd_addr];
  end

  // Read-valid flag travelling with the RAM output; masks unwritten entries.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= rd_ok;
  end

  assign signal_out = vld_p1 ? rd_data_p1 : '0;

endmodule

// File: tb/tb_waveform_buffer.sv
// Self-checking bench for waveform_buffer (default parameters).
// Reference model: the list of kept samples in arrival order (at most DEPTH,
// oldest first); each snapshot copies that list and column c must show
// entry c of the copy, or 0 past its end.
module tb_waveform_buffer;
  localparam int DEPTH = 1024;
  localparam int DECIM = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [7:0]  sample_in;
  logic [10:0] hcount;
  logic [9:0]  vcount;
`ifdef WAVEBUF_FREEZE_EN
  logic        freeze;
`endif
  logic [7:0]  signal_out;
  logic        frame_ready;
  logic [10:0] fill_count;

  always #5 clock = ~clock;

  waveform_buffer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .hcount       (hcount),
    .vcount       (vcount),
`ifdef WAVEBUF_FREEZE_EN
    .freeze       (freeze),
`endif
    .signal_out   (signal_out),
    .frame_ready  (frame_ready),
    .fill_count   (fill_count)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  int unsigned strobes = 0;
  logic [7:0]  hist[$];
  logic [7:0]  disp[$];
  bit          frozen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_strobe(input logic [7:0] v);
    if (!frozen) begin
      if (strobes % DECIM == 0) begin
        hist.push_back(v);
        if (hist.size() > DEPTH) void'(hist.pop_front());
      end
      strobes++;
    end
  endtask

  task automatic send(input logic [7:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    hcount       = 11'($urandom_range(0, 2047));
    tick();
    sample_valid = 1'b0;
    model_strobe(v);
  endtask

  task automatic idle_rand();
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      sample_in = 8'($urandom);
      tick();
    end
  endtask

  task automatic scan();
    logic [7:0] e;
    int cols[$];
    for (int c = 0; c < DEPTH; c++) cols.push_back(c);
    cols.push_back(1024); cols.push_back(1025); cols.push_back(1031);
    cols.push_back(1500); cols.push_back(2047);
    foreach (cols[k]) begin
      hcount = 11'(cols[k]);
      tick();
      e = (cols[k] < disp.size()) ? disp[cols[k]] : 8'd0;
      chk($sformatf("col%0d", cols[k]), 32'(signal_out), 32'(e));
    end
    chk("frame_ready_scan", 32'(frame_ready), 0);
  endtask

  task automatic snapshot_only();
    vcount = 10'd768;
    hcount = 11'd0;
    tick();
    if (!frozen) disp = hist;
    chk("frame_ready_hi", 32'(frame_ready), 1);
    vcount = 10'd0;
    hcount = 11'd1;
    tick();
    chk("frame_ready_lo", 32'(frame_ready), 0);
  endtask

  task automatic frame();
    snapshot_only();
    chk("fill_count", 32'(fill_count), 32'(hist.size()));
    scan();
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 8'd0;
    hcount       = 11'd0;
    vcount       = 10'd0;
`ifdef WAVEBUF_FREEZE_EN
    freeze       = 1'b0;
`endif
    tick(); tick();
    chk("rst_signal_out", 32'(signal_out), 0);
    chk("rst_fill_count", 32'(fill_count), 0);
    chk("rst_frame_ready", 32'(frame_ready), 0);
    reset_n = 1'b1;
    tick();

    // Empty frame: everything masked.
    frame();

    // 40 strobes 0..39 with DECIM=4 keep 0,4,...,36.
    for (int i = 0; i < 40; i++) send(8'(i));
    frame();

    // Strobe on the snapshot cycle: excluded now, shown next frame.
    chk("fill_pre_coinc", 32'(fill_count), 32'(hist.size()));
    sample_valid = 1'b1;
    sample_in    = 8'hA5;
    vcount       = 10'd768;
    hcount       = 11'd0;
    tick();
    disp = hist;
    model_strobe(8'hA5);
    chk("frame_ready_coinc", 32'(frame_ready), 1);
    chk("fill_post_coinc", 32'(fill_count), 32'(hist.size()));
    sample_valid = 1'b0;
    vcount       = 10'd0;
    scan();
    frame();

    // Random partial fills with gaps.
    for (int f = 0; f < 3; f++) begin
      int n;
      n = $urandom_range(1, 600);
      for (int i = 0; i < n; i++) begin
        send(8'($urandom));
        idle_rand();
      end
      frame();
    end

    // Overfill the ring so base anchors at the write pointer.
    for (int i = 0; i < 4200; i++) send(8'($urandom));
    frame();
    for (int i = 0; i < 777; i++) send(8'($urandom));
    frame();

    // Asynchronous reset mid-line after data is on screen.
    hcount = 11'd5;
    tick();
    chk("pre_reset_col5", 32'(signal_out), 32'(disp[5]));
    #2 reset_n = 1'b0;
    #1;
    chk("async_signal_out", 32'(signal_out), 0);
    chk("async_fill_count", 32'(fill_count), 0);
    chk("async_frame_ready", 32'(frame_ready), 0);
    tick();
    reset_n = 1'b1;
    hist.delete();
    disp.delete();
    strobes = 0;
    tick();
    chk("post_reset_signal_out", 32'(signal_out), 0);
    frame();

    // Recovery: 200 kept samples.
    for (int i = 0; i < 800; i++) send(8'($urandom));
    frame();

`ifdef WAVEBUF_FREEZE_EN
    freeze = 1'b1;
    frozen = 1'b1;
    for (int i = 0; i < 50; i++) send(8'($urandom));
    frame();
    frame();
    freeze = 1'b0;
    frozen = 1'b0;
    for (int i = 0; i < 20; i++) send(8'($urandom));
    frame();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
